// File: rtl/board_state_rx.sv
// Single-wire async receiver: 2-flop synchronizer, mid-bit sampling, one N_BITS word per frame.
// Latency about (N_BITS+1.5)*BAUD_DIV+3 cycles from start edge to valid_out; no backpressure (strobes are fire-and-forget).
module board_state_rx #(
    parameter int BAUD_DIV = 868,
    parameter int N_BITS   = 162
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rx_in,
    output logic [N_BITS-1:0] data_out,
    output logic              valid_out,
    output logic              error_out,
    output logic              busy_out
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int CW = $clog2(N_BITS + 1);
    localparam logic [BW-1:0] HALF_END = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] FULL_END = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(N_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t            state;
    logic              rx_m;
    logic              rx_s;
    logic              rx_prev;
    logic [BW-1:0]     baud_cnt;
    logic [CW-1:0]     bit_cnt;
    logic [N_BITS-1:0] shift_reg;

    assign busy_out = (state != IDLE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            error_out <= 1'b0;
        end else begin
            rx_m      <= rx_in;
            rx_s      <= rx_m;
            rx_prev   <= rx_s;
            valid_out <= 1'b0;
            error_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_END) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        // A start bit that is already high again at mid-bit was a glitch.
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == FULL_END) begin
                        baud_cnt           <= '0;
                        shift_reg[bit_cnt] <= rx_s;
                        bit_cnt            <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == FULL_END) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            data_out  <= shift_reg;
                            valid_out <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            error_out <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // A line held low must return high before a new start edge can count.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_state_rx.sv
// Directed frames into board_state_rx; expected strobes queued at stimulus time, popped by a monitor.
module tb_board_state_rx;
    localparam int BD  = 32;
    localparam int NB  = 162;
    localparam int LAT = (2 * (NB + 1) + 1) * BD / 2 + 3;

    typedef struct {
        logic          is_err;
        logic [NB-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic [NB-1:0] data_out;
    logic          valid_out;
    logic          error_out;
    logic          busy_out;

    int            cyc     = 0;
    int            nchecks = 0;
    int            nerr    = 0;
    exp_t          expq[$];
    logic [NB-1:0] last_good = '0;

    board_state_rx #(.BAUD_DIV(BD), .N_BITS(NB)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .rx_in    (rx),
        .data_out (data_out),
        .valid_out(valid_out),
        .error_out(error_out),
        .busy_out (busy_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] req);
        nchecks++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // abort_at >= 0 pulses reset in the middle of that data bit; no response is then expected.
    task automatic send_frame(input logic [NB-1:0] d, input logic stop_val, input int abort_at);
        exp_t e;
        if (abort_at < 0) begin
            e.is_err = !stop_val;
            e.data   = stop_val ? d : last_good;
            e.cyc    = cyc + LAT;
            expq.push_back(e);
            if (stop_val) last_good = d;
        end
        rx = 1'b0;
        tick(BD);
        for (int i = 0; i < NB; i++) begin
            rx = d[i];
            if (i == abort_at) begin
                tick(BD / 2);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                chk("abort_busy", NB'(busy_out), NB'(1'b0));
                chk("abort_data", data_out, '0);
                last_good = '0;
                tick(BD - BD / 2 - 1);
            end else begin
                tick(BD);
            end
        end
        rx = stop_val;
        tick(BD);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (valid_out || error_out)) begin
            nchecks++;
            if (valid_out && error_out) begin
                nerr++;
                $display("FAIL strobe_excl: valid=1 error=1 want one-hot (cycle %0d)", cyc);
            end else if (expq.size() == 0) begin
                nerr++;
                $display("FAIL spurious_strobe: valid=%0b error=%0b want none (cycle %0d)",
                         valid_out, error_out, cyc);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if (error_out !== e.is_err) begin
                    nerr++;
                    $display("FAIL strobe_kind: error=%0b want %0b (cycle %0d)", error_out, e.is_err, cyc);
                end
                nchecks++;
                if (data_out !== e.data) begin
                    nerr++;
                    $display("FAIL strobe_data: got %h want %h", data_out, e.data);
                end
                nchecks++;
                if (cyc < e.cyc - 3 || cyc > e.cyc + 3) begin
                    nerr++;
                    $display("FAIL strobe_latency: cycle %0d want %0d +/-3", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int bad;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("reset_data", data_out, '0);
        chk("reset_valid", NB'(valid_out), NB'(1'b0));
        chk("reset_error", NB'(error_out), NB'(1'b0));
        chk("reset_busy", NB'(busy_out), NB'(1'b0));

        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            tick(1);
            if (busy_out !== 1'b0) bad++;
        end
        chk("idle_busy_cycles", NB'(bad), '0);
        chk("idle_data", data_out, '0);

        send_frame({2'b10, {40{4'hA}}}, 1'b1, -1);
        tick(20);
        chk("frame1_data", data_out, {2'b10, {40{4'hA}}});

        send_frame(NB'(1), 1'b1, -1);
        send_frame('1, 1'b1, -1);
        tick(20);
        chk("b2b_data", data_out, '1);

        rx = 1'b0;
        c0 = cyc;
        tick(BD / 2 - 4);
        rx = 1'b1;
        tick(10 - (cyc - c0));
        chk("glitch_busy_hi", NB'(busy_out), NB'(1'b1));
        tick(22 - (cyc - c0));
        chk("glitch_busy_lo", NB'(busy_out), NB'(1'b0));
        tick(100);

        send_frame({2'b11, {40{4'h6}}}, 1'b0, -1);
        tick(2500);
        chk("hold_low_busy", NB'(busy_out), NB'(1'b1));
        chk("hold_low_data", data_out, '1);
        tick(2500);
        rx = 1'b1;
        tick(10);
        chk("released_busy", NB'(busy_out), NB'(1'b0));
        tick(50);
        send_frame({2'b01, {20{8'hC3}}}, 1'b1, -1);
        tick(20);
        chk("after_err_data", data_out, {2'b01, {20{8'hC3}}});

        send_frame({{82{1'b1}}, {20{4'h5}}}, 1'b1, 80);
        tick(100);
        chk("post_abort_data", data_out, '0);
        send_frame({2'b10, {20{8'h3C}}}, 1'b1, -1);
        tick(50);
        chk("final_data", data_out, {2'b10, {20{8'h3C}}});
        chk("queue_drained", NB'(expq.size()), '0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule
